// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: one 32-bit word load/store as two 16-bit SRAM phases with wait states.
// Optional MEM_BOUNDS_CHECK_EN rejects addresses outside the SRAM window and pulses addr_err.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               addr_err
);

  localparam int unsigned PH   = WAIT_CYCLES + 1;
  localparam int unsigned CntW = (PH > 1) ? $clog2(PH) : 1;
  localparam logic [CntW-1:0] CntLast    = CntW'(PH - 1);
  localparam logic [CntW-1:0] CntPenult  = CntW'((PH > 1) ? PH - 2 : 0);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e             state;
  logic [CntW-1:0]    cnt;
  logic               is_write;
  logic [SRAM_AW-2:0] word_q;
  logic [15:0]        wdata_hi_q;
  logic               err_q;
  logic [31:0]        off;
  logic               req;
  logic               bad;

  assign off   = addr - ADDR_BASE;
  assign req   = mem_read | mem_write;
  assign ready = ~req | (state == StDone);

`ifdef MEM_BOUNDS_CHECK_EN
  assign bad      = (addr < ADDR_BASE) || (off[31:SRAM_AW+1] != '0);
  assign addr_err = err_q;
  logic unused_off;
  assign unused_off = ^off[1:0];
`else
  assign bad      = 1'b0;
  assign addr_err = 1'b0;
  logic unused_off;
  assign unused_off = ^{off[1:0], off[31:SRAM_AW+1], err_q};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= StIdle;
      cnt        <= '0;
      is_write   <= 1'b0;
      word_q     <= '0;
      wdata_hi_q <= '0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        StIdle: begin
          if (req) begin
            // Write wins when both requests are raised together.
            is_write   <= mem_write;
            word_q     <= off[SRAM_AW:2];
            wdata_hi_q <= wdata[31:16];
            cnt        <= '0;
            if (bad) begin
              state <= StDone;
              rdata <= '0;
              err_q <= 1'b1;
            end else begin
              state      <= StLo;
              sram_addr  <= {off[SRAM_AW:2], 1'b0};
              sram_dq_o  <= wdata[15:0];
              sram_dq_oe <= mem_write;
              sram_we_n  <= ~mem_write;
            end
          end
        end
        StLo: begin
          if (cnt == CntLast) begin
            if (!is_write) rdata[15:0] <= sram_dq_i;
            state     <= StHi;
            cnt       <= '0;
            sram_addr <= {word_q, 1'b1};
            sram_dq_o <= wdata_hi_q;
            sram_we_n <= ~is_write;
          end else begin
            // Release we_n on the last cycle so data/address hold past the strobe.
            cnt       <= cnt + 1'b1;
            sram_we_n <= ~is_write | (cnt == CntPenult);
          end
        end
        StHi: begin
          if (cnt == CntLast) begin
            if (!is_write) rdata[31:16] <= sram_dq_i;
            state      <= StDone;
            cnt        <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt       <= cnt + 1'b1;
            sram_we_n <= ~is_write | (cnt == CntPenult);
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule
